// File: rtl/hamm_rx_deser_if.sv
// Serial-in / codeword-out bus for the Hamming(7,4) receive deserializer.
// The master side drives serial bits and ready; the slave (deserializer) returns codewords.
interface hamm_rx_deser_if;
    logic       bit_in;
    logic       bit_valid;
    logic       bit_sync;
    logic       hamm_ready;
    logic [0:6] d_hamm;
    logic       hamm_valid;

    modport master (
        output bit_in,
        output bit_valid,
        output bit_sync,
        output hamm_ready,
        input  d_hamm,
        input  hamm_valid
    );

    modport slave (
        input  bit_in,
        input  bit_valid,
        input  bit_sync,
        input  hamm_ready,
        output d_hamm,
        output hamm_valid
    );
endinterface

// File: rtl/hamm_rx_deser.sv
// Collects framed serial bits into 7-bit Hamming codewords with a valid/ready output,
// flagging framing faults (resync, timeout, orphan bit) and overruns.
module hamm_rx_deser #(
    parameter int unsigned CNT_W   = 8,
    parameter int unsigned TIMEOUT = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    hamm_rx_deser_if.slave       bus,
    input  logic                 clr_flags,
    output logic                 sync_err,
    output logic                 overrun,
    output logic [CNT_W-1:0]     frame_cnt
);

    localparam int unsigned BIT_W = 3;
    localparam int unsigned TO_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [BIT_W-1:0] LAST_IDX = BIT_W'(6);

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t            state, state_nxt;
    logic [BIT_W-1:0]  cnt, cnt_nxt;
    logic [0:6]        shreg, shreg_nxt;
    logic [TO_W-1:0]   to_cnt, to_nxt;
    logic [0:6]        d_hamm, d_hamm_nxt;
    logic              hamm_valid, hamm_valid_nxt;
    logic              sync_err_nxt, overrun_nxt;
    logic [CNT_W-1:0]  frame_cnt_nxt;
    logic              complete, load, set_sync;

    assign bus.d_hamm     = d_hamm;
    assign bus.hamm_valid = hamm_valid;

    // State and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            cnt        <= '0;
            shreg      <= '0;
            to_cnt     <= '0;
            d_hamm     <= '0;
            hamm_valid <= 1'b0;
            sync_err   <= 1'b0;
            overrun    <= 1'b0;
            frame_cnt  <= '0;
        end else begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            shreg      <= shreg_nxt;
            to_cnt     <= to_nxt;
            d_hamm     <= d_hamm_nxt;
            hamm_valid <= hamm_valid_nxt;
            sync_err   <= sync_err_nxt;
            overrun    <= overrun_nxt;
            frame_cnt  <= frame_cnt_nxt;
        end
    end

    // Framing FSM, output register load and flag update
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        shreg_nxt = shreg;
        to_nxt    = to_cnt;
        complete  = 1'b0;
        set_sync  = 1'b0;

        case (state)
            IDLE: begin
                to_nxt = '0;
                if (bus.bit_valid) begin
                    if (bus.bit_sync) begin
                        shreg_nxt    = '0;
                        shreg_nxt[0] = bus.bit_in;
                        cnt_nxt      = BIT_W'(1);
                        state_nxt    = SHIFT;
                    end else begin
                        set_sync = 1'b1;
                    end
                end
            end
            SHIFT: begin
                if (bus.bit_valid) begin
                    to_nxt = '0;
                    if (bus.bit_sync) begin
                        // Resync: restart the frame on this bit without losing a cycle
                        set_sync     = 1'b1;
                        shreg_nxt    = '0;
                        shreg_nxt[0] = bus.bit_in;
                        cnt_nxt      = BIT_W'(1);
                    end else begin
                        shreg_nxt[cnt] = bus.bit_in;
                        if (cnt == LAST_IDX) begin
                            complete  = 1'b1;
                            cnt_nxt   = '0;
                            state_nxt = IDLE;
                        end else begin
                            cnt_nxt = cnt + BIT_W'(1);
                        end
                    end
                end else if (TIMEOUT != 0) begin
                    if (to_cnt == TO_W'(TIMEOUT - 1)) begin
                        set_sync  = 1'b1;
                        to_nxt    = '0;
                        cnt_nxt   = '0;
                        state_nxt = IDLE;
                    end else begin
                        to_nxt = to_cnt + TO_W'(1);
                    end
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
                to_nxt    = '0;
            end
        endcase

        // A finished word only fits if the output register is empty or draining now
        load = complete && (!hamm_valid || bus.hamm_ready);

        d_hamm_nxt     = load ? shreg_nxt : d_hamm;
        frame_cnt_nxt  = load ? frame_cnt + CNT_W'(1) : frame_cnt;
        if (load)
            hamm_valid_nxt = 1'b1;
        else if (hamm_valid && bus.hamm_ready)
            hamm_valid_nxt = 1'b0;
        else
            hamm_valid_nxt = hamm_valid;

        sync_err_nxt = (sync_err && !clr_flags) || set_sync;
        overrun_nxt  = (overrun && !clr_flags) || (complete && !load);
    end

endmodule

// File: tb/tb_hamm_rx_deser.sv
// Directed bench for hamm_rx_deser: framing, handshake, overrun, resync,
// timeout, flag clearing, counter wrap and mid-frame reset.
module tb_hamm_rx_deser;

    logic       clk;
    logic       rst_n;
    logic       clr_flags;
    logic       sync_err;
    logic       overrun;
    logic [7:0] frame_cnt;

    int n_vec;
    int n_err;

    hamm_rx_deser_if bus ();

    hamm_rx_deser #(.CNT_W(8), .TIMEOUT(16)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus),
        .clr_flags (clr_flags),
        .sync_err  (sync_err),
        .overrun   (overrun),
        .frame_cnt (frame_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_vec++;
        assert (obs === exp_v) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b, input logic s);
        bus.bit_in    = b;
        bus.bit_valid = 1'b1;
        bus.bit_sync  = s;
        step();
        bus.bit_in    = 1'b0;
        bus.bit_valid = 1'b0;
        bus.bit_sync  = 1'b0;
    endtask

    task automatic send_frame(input logic [0:6] w);
        for (int i = 0; i < 7; i++)
            send_bit(w[i], (i == 0));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++)
            step();
    endtask

    initial begin
        logic [0:6] wa, wb, wc, we, ww, wg, wf;
        n_vec = 0;
        n_err = 0;
        rst_n          = 1'b0;
        clr_flags      = 1'b0;
        bus.bit_in     = 1'b0;
        bus.bit_valid  = 1'b0;
        bus.bit_sync   = 1'b0;
        bus.hamm_ready = 1'b0;

        // Reset state
        #12;
        check("rst_d_hamm",    32'(bus.d_hamm),     32'h0);
        check("rst_valid",     32'(bus.hamm_valid), 32'h0);
        check("rst_sync_err",  32'(sync_err),       32'h0);
        check("rst_overrun",   32'(overrun),        32'h0);
        check("rst_frame_cnt", 32'(frame_cnt),      32'h0);
        step();
        rst_n = 1'b1;
        step();

        // Basic frame 1,0,1,1,0,0,1 with ready high
        bus.hamm_ready = 1'b1;
        send_frame(7'b1011001);
        check("basic_d_hamm",  32'(bus.d_hamm),     32'h59);
        check("basic_valid",   32'(bus.hamm_valid), 32'h1);
        check("basic_cnt",     32'(frame_cnt),      32'h1);
        check("basic_syncerr", 32'(sync_err),       32'h0);
        check("basic_overrun", 32'(overrun),        32'h0);
        step();
        check("basic_drain_valid", 32'(bus.hamm_valid), 32'h0);
        check("basic_drain_hold",  32'(bus.d_hamm),     32'h59);

        // Two frames back-to-back with ready low: second one dropped
        wa = 7'b0101010;
        wb = 7'b1110000;
        bus.hamm_ready = 1'b0;
        send_frame(wa);
        send_frame(wb);
        check("ovr_flag",  32'(overrun),        32'h1);
        check("ovr_hold",  32'(bus.d_hamm),     32'(wa));
        check("ovr_valid", 32'(bus.hamm_valid), 32'h1);
        check("ovr_cnt",   32'(frame_cnt),      32'h2);
        idle(3);
        check("ovr_stable", 32'(bus.d_hamm), 32'(wa));
        bus.hamm_ready = 1'b1;
        step();
        bus.hamm_ready = 1'b0;
        check("ovr_ready_clears", 32'(bus.hamm_valid), 32'h0);
        clr_flags = 1'b1;
        step();
        clr_flags = 1'b0;
        check("ovr_clr", 32'(overrun), 32'h0);

        // Resync after three bits, then a full frame delivered intact
        wc = 7'b0011101;
        bus.hamm_ready = 1'b1;
        send_bit(1'b1, 1'b1);
        send_bit(1'b1, 1'b0);
        send_bit(1'b0, 1'b0);
        send_frame(wc);
        check("resync_syncerr", 32'(sync_err),   32'h1);
        check("resync_d_hamm",  32'(bus.d_hamm), 32'(wc));
        check("resync_cnt",     32'(frame_cnt),  32'h3);
        clr_flags = 1'b1;
        step();
        clr_flags = 1'b0;
        check("resync_clr", 32'(sync_err), 32'h0);

        // 16-cycle gap after 4 bits aborts; the trailing 3 bits must not complete a word
        send_bit(1'b1, 1'b1);
        send_bit(1'b1, 1'b0);
        send_bit(1'b0, 1'b0);
        send_bit(1'b1, 1'b0);
        idle(16);
        check("to_syncerr", 32'(sync_err), 32'h1);
        send_bit(1'b0, 1'b0);
        send_bit(1'b0, 1'b0);
        send_bit(1'b1, 1'b0);
        check("to_no_word_valid", 32'(bus.hamm_valid), 32'h0);
        check("to_no_word_cnt",   32'(frame_cnt),      32'h3);
        clr_flags = 1'b1;
        step();
        clr_flags = 1'b0;

        // 15-cycle gap is tolerated
        we = 7'b1101001;
        for (int i = 0; i < 4; i++)
            send_bit(we[i], (i == 0));
        idle(15);
        for (int i = 4; i < 7; i++)
            send_bit(we[i], 1'b0);
        check("gap15_d_hamm",  32'(bus.d_hamm),     32'(we));
        check("gap15_valid",   32'(bus.hamm_valid), 32'h1);
        check("gap15_cnt",     32'(frame_cnt),      32'h4);
        check("gap15_syncerr", 32'(sync_err),       32'h0);
        step();

        // Orphan bit with clr_flags in the same cycle: set wins
        clr_flags = 1'b1;
        send_bit(1'b1, 1'b0);
        check("clr_vs_set", 32'(sync_err), 32'h1);
        step();
        clr_flags = 1'b0;
        check("clr_only", 32'(sync_err), 32'h0);

        // Counter wrap: 251 frames to 255, then one more wraps to 0
        for (int i = 0; i < 251; i++)
            send_frame(7'(i + 1));
        check("wrap_255", 32'(frame_cnt), 32'hff);
        ww = 7'b1001011;
        send_frame(ww);
        check("wrap_0",      32'(frame_cnt),  32'h0);
        check("wrap_d_hamm", 32'(bus.d_hamm), 32'(ww));
        check("wrap_no_ovr", 32'(overrun),    32'h0);

        // Populate outputs, then reset mid-frame
        wg = 7'b0110011;
        bus.hamm_ready = 1'b0;
        step();
        send_frame(wg);
        send_bit(1'b1, 1'b0);
        check("pre_rst_syncerr", 32'(sync_err), 32'h1);
        send_bit(1'b1, 1'b1);
        send_bit(1'b0, 1'b0);
        send_bit(1'b1, 1'b0);
        send_bit(1'b1, 1'b0);
        rst_n = 1'b0;
        #1;
        check("mid_rst_d_hamm",  32'(bus.d_hamm),     32'h0);
        check("mid_rst_valid",   32'(bus.hamm_valid), 32'h0);
        check("mid_rst_syncerr", 32'(sync_err),       32'h0);
        check("mid_rst_cnt",     32'(frame_cnt),      32'h0);
        step();
        rst_n = 1'b1;
        bus.hamm_ready = 1'b1;
        step();
        wf = 7'b1100110;
        send_frame(wf);
        check("post_rst_d_hamm",  32'(bus.d_hamm),     32'(wf));
        check("post_rst_valid",   32'(bus.hamm_valid), 32'h1);
        check("post_rst_cnt",     32'(frame_cnt),      32'h1);
        check("post_rst_syncerr", 32'(sync_err),       32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
